// File: rtl/bridge_pkg.sv
// Shared definitions for the core/peripheral bridge: port codes and FSM encodings.
package bridge_pkg;

    localparam logic [1:0] CODE_RESULT = 2'b00;
    localparam logic [1:0] CODE_CMD0   = 2'b01;
    localparam logic [1:0] CODE_CMD1   = 2'b10;
    localparam logic [1:0] CODE_FLUSH  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } bridge_state_t;

endpackage

// File: rtl/bridge_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers and a combinational head output.
module bridge_sync_fifo #(
    parameter int WIDTH     = 34,
    parameter int ADDR_BITS = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_BITS:0] wr_ptr_reg;
    logic [ADDR_BITS:0] rd_ptr_reg;
    logic               push_ok;
    logic               pop_ok;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[ADDR_BITS] != rd_ptr_reg[ADDR_BITS]) &&
                   (wr_ptr_reg[ADDR_BITS-1:0] == rd_ptr_reg[ADDR_BITS-1:0]);

    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_reg[ADDR_BITS-1:0]] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    assign dout = mem[rd_ptr_reg[ADDR_BITS-1:0]];

endmodule

// File: rtl/core_peripheral_bridge.sv
// Peripheral endpoint of the core I/O port: buffers core beats for the host and
// forwards host commands to the core as spaced single-cycle pulses.
module core_peripheral_bridge
    import bridge_pkg::*;
#(
    parameter int CORE           = 0,
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_ADDR_BITS = 3,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            to_peripheral,
    input  logic [DATA_WIDTH-1:0] to_peripheral_data,
    input  logic                  to_peripheral_valid,
    output logic [1:0]            from_peripheral,
    output logic [DATA_WIDTH-1:0] from_peripheral_data,
    output logic                  from_peripheral_valid,
    output logic [DATA_WIDTH+1:0] host_rd_data,
    output logic                  host_rd_valid,
    input  logic                  host_rd_ready,
    input  logic [1:0]            host_cmd,
    input  logic [DATA_WIDTH-1:0] host_cmd_data,
    input  logic                  host_cmd_valid,
    output logic                  host_cmd_ready,
    output logic [15:0]           overflow_count,
    input  logic                  report
);

    bridge_state_t         state_reg;
    logic [7:0]            gap_cnt_reg;
    logic                  cmd_ready_reg;
    logic [1:0]            fp_code_reg;
    logic [DATA_WIDTH-1:0] fp_data_reg;
    logic                  fp_valid_reg;
    logic [15:0]           overflow_reg;

    logic                  fifo_empty;
    logic                  fifo_full;
    logic [DATA_WIDTH+1:0] fifo_dout;
    logic                  pop;
    logic                  drop;
    logic                  flush;

    // Occupancy reporting has no hardware realisation; the input is sunk here.
    logic unused_report;
    assign unused_report = report ^ (CORE < 0);

    assign flush = (state_reg == ST_IDLE) && host_cmd_valid && (host_cmd == CODE_FLUSH);
    assign pop   = !fifo_empty && host_rd_ready;
    assign drop  = to_peripheral_valid && fifo_full && !pop;

    bridge_sync_fifo #(
        .WIDTH     (DATA_WIDTH + 2),
        .ADDR_BITS (FIFO_ADDR_BITS)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (to_peripheral_valid),
        .pop   (pop),
        .flush (flush),
        .din   ({to_peripheral, to_peripheral_data}),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign host_rd_valid = !fifo_empty;
    // Unwritten storage is never exposed: the head reads as zero while empty.
    assign host_rd_data  = fifo_empty ? '0 : fifo_dout;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            overflow_reg <= '0;
        end else if (drop && (overflow_reg != 16'hFFFF)) begin
            overflow_reg <= overflow_reg + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            gap_cnt_reg   <= '0;
            cmd_ready_reg <= 1'b1;
            fp_code_reg   <= '0;
            fp_data_reg   <= '0;
            fp_valid_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (host_cmd_valid) begin
                        cmd_ready_reg <= 1'b0;
                        if (host_cmd == CODE_FLUSH) begin
                            state_reg   <= ST_GAP;
                            gap_cnt_reg <= 8'(GAP_CYCLES - 1);
                        end else begin
                            state_reg    <= ST_SEND;
                            fp_code_reg  <= host_cmd;
                            fp_data_reg  <= host_cmd_data;
                            fp_valid_reg <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    fp_valid_reg <= 1'b0;
                    state_reg    <= ST_GAP;
                    gap_cnt_reg  <= 8'(GAP_CYCLES - 1);
                end
                ST_GAP: begin
                    if (gap_cnt_reg == 8'd0) begin
                        state_reg     <= ST_IDLE;
                        cmd_ready_reg <= 1'b1;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - 8'd1;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    cmd_ready_reg <= 1'b1;
                    fp_valid_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign from_peripheral       = fp_code_reg;
    assign from_peripheral_data  = fp_data_reg;
    assign from_peripheral_valid = fp_valid_reg;
    assign host_cmd_ready        = cmd_ready_reg;
    assign overflow_count        = overflow_reg;

endmodule

// File: tb/tb_core_peripheral_bridge.sv
// Directed bench for core_peripheral_bridge with hand-computed expectations.
module tb_core_peripheral_bridge;

    logic        clock;
    logic        reset;
    logic [1:0]  to_peripheral;
    logic [31:0] to_peripheral_data;
    logic        to_peripheral_valid;
    logic [1:0]  from_peripheral;
    logic [31:0] from_peripheral_data;
    logic        from_peripheral_valid;
    logic [33:0] host_rd_data;
    logic        host_rd_valid;
    logic        host_rd_ready;
    logic [1:0]  host_cmd;
    logic [31:0] host_cmd_data;
    logic        host_cmd_valid;
    logic        host_cmd_ready;
    logic [15:0] overflow_count;
    logic        report;

    int tests;
    int fails;

    core_peripheral_bridge dut (
        .clock                 (clock),
        .reset                 (reset),
        .to_peripheral         (to_peripheral),
        .to_peripheral_data    (to_peripheral_data),
        .to_peripheral_valid   (to_peripheral_valid),
        .from_peripheral       (from_peripheral),
        .from_peripheral_data  (from_peripheral_data),
        .from_peripheral_valid (from_peripheral_valid),
        .host_rd_data          (host_rd_data),
        .host_rd_valid         (host_rd_valid),
        .host_rd_ready         (host_rd_ready),
        .host_cmd              (host_cmd),
        .host_cmd_data         (host_cmd_data),
        .host_cmd_valid        (host_cmd_valid),
        .host_cmd_ready        (host_cmd_ready),
        .overflow_count        (overflow_count),
        .report                (report)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[TB] check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        to_peripheral = 2'b00;
        to_peripheral_data = '0;
        to_peripheral_valid = 1'b0;
        host_rd_ready = 1'b0;
        host_cmd = 2'b00;
        host_cmd_data = '0;
        host_cmd_valid = 1'b0;
        report = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check("rst_rd_valid", 34'(host_rd_valid), 34'd0);
        check("rst_rd_data", host_rd_data, 34'd0);
        check("rst_fp_valid", 34'(from_peripheral_valid), 34'd0);
        check("rst_fp_data", 34'(from_peripheral_data), 34'd0);
        check("rst_ovf", 34'(overflow_count), 34'd0);
        check("rst_cmd_ready", 34'(host_cmd_ready), 34'd1);

        // 1: beats 5,6,7 with host stalled, then drain
        to_peripheral_valid = 1'b1;
        to_peripheral_data = 32'd5;
        step();
        check("t1_valid_rise", 34'(host_rd_valid), 34'd1);
        check("t1_head", host_rd_data, {2'b00, 32'd5});
        to_peripheral_data = 32'd6;
        step();
        to_peripheral_data = 32'd7;
        step();
        to_peripheral_valid = 1'b0;
        step();
        check("t1_hold", host_rd_data, {2'b00, 32'd5});
        host_rd_ready = 1'b1;
        check("t1_pop5", host_rd_data, {2'b00, 32'd5});
        step();
        check("t1_pop6", host_rd_data, {2'b00, 32'd6});
        step();
        check("t1_pop7", host_rd_data, {2'b00, 32'd7});
        step();
        check("t1_empty", 34'(host_rd_valid), 34'd0);
        host_rd_ready = 1'b0;

        // 2: ten beats into a depth-8 FIFO
        to_peripheral_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            to_peripheral_data = 32'(i);
            step();
        end
        to_peripheral_valid = 1'b0;
        check("t2_ovf", 34'(overflow_count), 34'd2);
        host_rd_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("t2_drain", host_rd_data, {2'b00, 32'(i)});
            step();
        end
        check("t2_empty", 34'(host_rd_valid), 34'd0);
        host_rd_ready = 1'b0;

        // 3: full FIFO, push and pop together
        to_peripheral_valid = 1'b1;
        for (int i = 11; i <= 18; i++) begin
            to_peripheral_data = 32'(i);
            step();
        end
        check("t3_head", host_rd_data, {2'b00, 32'd11});
        to_peripheral_data = 32'd19;
        host_rd_ready = 1'b1;
        step();
        host_rd_ready = 1'b0;
        check("t3_ovf_same", 34'(overflow_count), 34'd2);
        check("t3_head2", host_rd_data, {2'b00, 32'd12});
        to_peripheral_data = 32'd20;
        step();
        to_peripheral_valid = 1'b0;
        check("t3_still_full", 34'(overflow_count), 34'd3);
        host_rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        host_rd_ready = 1'b0;
        check("t3_head16", host_rd_data, {2'b00, 32'd16});

        // 4: command 01/DEADBEEF held valid
        host_cmd = 2'b01;
        host_cmd_data = 32'hDEADBEEF;
        host_cmd_valid = 1'b1;
        check("t4_ready_idle", 34'(host_cmd_ready), 34'd1);
        step();
        check("t4_pulse", 34'(from_peripheral_valid), 34'd1);
        check("t4_code", 34'(from_peripheral), 34'd1);
        check("t4_data", 34'(from_peripheral_data), 34'h0DEADBEEF);
        check("t4_ready_send", 34'(host_cmd_ready), 34'd0);
        step();
        check("t4_pulse_end", 34'(from_peripheral_valid), 34'd0);
        check("t4_code_hold", 34'(from_peripheral), 34'd1);
        check("t4_ready_gap1", 34'(host_cmd_ready), 34'd0);
        step();
        check("t4_no_repulse", 34'(from_peripheral_valid), 34'd0);
        check("t4_ready_gap2", 34'(host_cmd_ready), 34'd0);
        step();
        check("t4_no_repulse2", 34'(from_peripheral_valid), 34'd0);
        check("t4_ready_back", 34'(host_cmd_ready), 34'd1);
        host_cmd = 2'b10;
        host_cmd_data = 32'h12345678;
        step();
        host_cmd_valid = 1'b0;
        check("t4_second", 34'(from_peripheral_valid), 34'd1);
        check("t4_second_data", 34'(from_peripheral_data), 34'h012345678);
        check("t4_second_code", 34'(from_peripheral), 34'd2);
        check("t4_queue_kept", host_rd_data, {2'b00, 32'd16});
        step();
        step();
        step();
        check("t4_idle_again", 34'(host_cmd_ready), 34'd1);

        // 5: FLUSH with 4 queued, overflow 3, and a core beat in the same cycle
        host_cmd = 2'b11;
        host_cmd_data = 32'h0;
        host_cmd_valid = 1'b1;
        to_peripheral_valid = 1'b1;
        to_peripheral_data = 32'd99;
        step();
        host_cmd_valid = 1'b0;
        to_peripheral_valid = 1'b0;
        check("t5_empty", 34'(host_rd_valid), 34'd0);
        check("t5_ovf_clr", 34'(overflow_count), 34'd0);
        check("t5_no_pulse", 34'(from_peripheral_valid), 34'd0);
        check("t5_fp_hold", 34'(from_peripheral), 34'd2);
        check("t5_ready_gap", 34'(host_cmd_ready), 34'd0);
        step();
        check("t5_no_pulse2", 34'(from_peripheral_valid), 34'd0);
        step();
        check("t5_ready_back", 34'(host_cmd_ready), 34'd1);

        // 6: reset during SEND with 3 queued
        to_peripheral_valid = 1'b1;
        for (int i = 21; i <= 23; i++) begin
            to_peripheral_data = 32'(i);
            step();
        end
        to_peripheral_valid = 1'b0;
        host_cmd = 2'b01;
        host_cmd_data = 32'h0000AAAA;
        host_cmd_valid = 1'b1;
        step();
        host_cmd_valid = 1'b0;
        check("t6_in_send", 34'(from_peripheral_valid), 34'd1);
        check("t6_queued", 34'(host_rd_valid), 34'd1);
        reset = 1'b1;
        step();
        check("t6_fp_valid", 34'(from_peripheral_valid), 34'd0);
        check("t6_fp_code", 34'(from_peripheral), 34'd0);
        check("t6_fp_data", 34'(from_peripheral_data), 34'd0);
        check("t6_rd_valid", 34'(host_rd_valid), 34'd0);
        check("t6_rd_data", host_rd_data, 34'd0);
        check("t6_ovf", 34'(overflow_count), 34'd0);
        reset = 1'b0;
        step();
        check("t6_ready", 34'(host_cmd_ready), 34'd1);
        check("t6_no_pulse", 34'(from_peripheral_valid), 34'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
